// File: rtl/dual_mem_sched_if.sv
// Requester and dual_mem pin bundle for dual_mem_sched.
// With DUAL_MEM_SCHED_STATS_EN defined the bundle also carries the stat counters.
interface dual_mem_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*DW-1:0] rsp_data;

    logic               we_1;
    logic               we_2;
    logic [AW-1:0]      wr_addr1;
    logic [AW-1:0]      wr_addr2;
    logic [DW-1:0]      data1;
    logic [DW-1:0]      data2;
    logic               re_1;
    logic               re_2;
    logic [AW-1:0]      re_addr1;
    logic [AW-1:0]      re_addr2;
    logic [DW-1:0]      read_out1;
    logic [DW-1:0]      read_out2;

`ifdef DUAL_MEM_SCHED_STATS_EN
    logic [31:0]        stat_grants;
    logic [15:0]        stat_stalls;
`endif

    // Requesters plus the memory side; drives requests and read data.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, read_out1, read_out2,
        input  req_ready, rsp_valid, rsp_data,
        input  we_1, we_2, wr_addr1, wr_addr2, data1, data2,
        input  re_1, re_2, re_addr1, re_addr2
`ifdef DUAL_MEM_SCHED_STATS_EN
        , input stat_grants, stat_stalls
`endif
    );

    // Scheduler view.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, read_out1, read_out2,
        output req_ready, rsp_valid, rsp_data,
        output we_1, we_2, wr_addr1, wr_addr2, data1, data2,
        output re_1, re_2, re_addr1, re_addr2
`ifdef DUAL_MEM_SCHED_STATS_EN
        , output stat_grants, stat_stalls
`endif
    );
endinterface

// File: rtl/dual_mem_sched.sv
// dual_mem_sched: grants up to 2 writes + 2 reads per cycle to dual_mem with
// independent round-robin pointers, resolves same-cycle address hazards and
// returns read data to the issuing requester 3 cycles after accept.
// Optional macro DUAL_MEM_SCHED_STATS_EN adds stat_grants / stat_stalls.
module dual_mem_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    dual_mem_sched_if.slave bus
);
    localparam int unsigned IW = $clog2(NREQ);

    // (base + k) mod NREQ for base, k < NREQ.
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    logic [IW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]   rd_ptr_q, rd_ptr_d;

    logic            w1_c, w2_c, r1_c, r2_c;
    logic [IW-1:0]   w1_idx_c, w2_idx_c, r1_idx_c, r2_idx_c;
    logic [AW-1:0]   w1_addr_c, w2_addr_c, r1_addr_c, r2_addr_c;
    logic [DW-1:0]   w1_data_c, w2_data_c;
    logic [NREQ-1:0] wr_gnt_c, rd_gnt_c;
    logic            ww_haz_c, rw_haz_c;
    logic [IW-1:0]   wi_c, ri_c;
    logic [AW-1:0]   wa_c, ra_c;

    logic            we_1_q, we_2_q, re_1_q, re_2_q;
    logic [AW-1:0]   wr_addr1_q, wr_addr2_q, re_addr1_q, re_addr2_q;
    logic [DW-1:0]   data1_q, data2_q;
    logic [IW-1:0]   iss_tag1_q, iss_tag2_q;
    logic            ret_v1_q, ret_v2_q;
    logic [IW-1:0]   ret_tag1_q, ret_tag2_q;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NREQ*DW-1:0] rsp_data_q, rsp_data_d;

    // Write scan from wr_ptr: first hit -> slot 1, next different-address hit -> slot 2.
    always_comb begin
        w1_c      = 1'b0;
        w2_c      = 1'b0;
        w1_idx_c  = '0;
        w2_idx_c  = '0;
        w1_addr_c = '0;
        w2_addr_c = '0;
        w1_data_c = '0;
        w2_data_c = '0;
        wr_gnt_c  = '0;
        ww_haz_c  = 1'b0;
        wi_c      = '0;
        wa_c      = '0;
        if (!rst) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                wi_c = wrap_idx(wr_ptr_q, k);
                wa_c = bus.req_addr[32'(wi_c)*AW +: AW];
                if (bus.req_valid[wi_c] && bus.req_we[wi_c]) begin
                    if (!w1_c) begin
                        w1_c          = 1'b1;
                        w1_idx_c      = wi_c;
                        w1_addr_c     = wa_c;
                        w1_data_c     = bus.req_wdata[32'(wi_c)*DW +: DW];
                        wr_gnt_c[wi_c] = 1'b1;
                    end else if (wa_c == w1_addr_c) begin
                        ww_haz_c = 1'b1;
                    end else if (!w2_c) begin
                        w2_c          = 1'b1;
                        w2_idx_c      = wi_c;
                        w2_addr_c     = wa_c;
                        w2_data_c     = bus.req_wdata[32'(wi_c)*DW +: DW];
                        wr_gnt_c[wi_c] = 1'b1;
                    end
                end
            end
        end
    end

    // Read scan from rd_ptr; reads colliding with a granted write wait a cycle.
    always_comb begin
        r1_c      = 1'b0;
        r2_c      = 1'b0;
        r1_idx_c  = '0;
        r2_idx_c  = '0;
        r1_addr_c = '0;
        r2_addr_c = '0;
        rd_gnt_c  = '0;
        rw_haz_c  = 1'b0;
        ri_c      = '0;
        ra_c      = '0;
        if (!rst) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                ri_c = wrap_idx(rd_ptr_q, k);
                ra_c = bus.req_addr[32'(ri_c)*AW +: AW];
                if (bus.req_valid[ri_c] && !bus.req_we[ri_c]) begin
                    if ((w1_c && ra_c == w1_addr_c) || (w2_c && ra_c == w2_addr_c)) begin
                        rw_haz_c = 1'b1;
                    end else if (!r1_c) begin
                        r1_c           = 1'b1;
                        r1_idx_c       = ri_c;
                        r1_addr_c      = ra_c;
                        rd_gnt_c[ri_c] = 1'b1;
                    end else if (!r2_c) begin
                        r2_c           = 1'b1;
                        r2_idx_c       = ri_c;
                        r2_addr_c      = ra_c;
                        rd_gnt_c[ri_c] = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.req_ready = wr_gnt_c | rd_gnt_c;

    // Pointers advance past the last granted requester of their type.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w2_c)      wr_ptr_d = wrap_idx(w2_idx_c, 1);
        else if (w1_c) wr_ptr_d = wrap_idx(w1_idx_c, 1);
        if (r2_c)      rd_ptr_d = wrap_idx(r2_idx_c, 1);
        else if (r1_c) rd_ptr_d = wrap_idx(r1_idx_c, 1);
    end

    // Round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Issue stage: registered dual_mem pins; addresses/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_1_q     <= 1'b0;
            we_2_q     <= 1'b0;
            re_1_q     <= 1'b0;
            re_2_q     <= 1'b0;
            wr_addr1_q <= '0;
            wr_addr2_q <= '0;
            re_addr1_q <= '0;
            re_addr2_q <= '0;
            data1_q    <= '0;
            data2_q    <= '0;
            iss_tag1_q <= '0;
            iss_tag2_q <= '0;
        end else begin
            we_1_q <= w1_c;
            we_2_q <= w2_c;
            re_1_q <= r1_c;
            re_2_q <= r2_c;
            if (w1_c) begin
                wr_addr1_q <= w1_addr_c;
                data1_q    <= w1_data_c;
            end
            if (w2_c) begin
                wr_addr2_q <= w2_addr_c;
                data2_q    <= w2_data_c;
            end
            if (r1_c) begin
                re_addr1_q <= r1_addr_c;
                iss_tag1_q <= r1_idx_c;
            end
            if (r2_c) begin
                re_addr2_q <= r2_addr_c;
                iss_tag2_q <= r2_idx_c;
            end
        end
    end

    // Route returning read data to the tagged requester.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (ret_v1_q) begin
            rsp_valid_d[ret_tag1_q]                = 1'b1;
            rsp_data_d[32'(ret_tag1_q)*DW +: DW]   = bus.read_out1;
        end
        if (ret_v2_q) begin
            rsp_valid_d[ret_tag2_q]                = 1'b1;
            rsp_data_d[32'(ret_tag2_q)*DW +: DW]   = bus.read_out2;
        end
    end

    // Tag pipeline second stage and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_v1_q    <= 1'b0;
            ret_v2_q    <= 1'b0;
            ret_tag1_q  <= '0;
            ret_tag2_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ret_v1_q    <= re_1_q;
            ret_v2_q    <= re_2_q;
            ret_tag1_q  <= iss_tag1_q;
            ret_tag2_q  <= iss_tag2_q;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.we_1      = we_1_q;
    assign bus.we_2      = we_2_q;
    assign bus.wr_addr1  = wr_addr1_q;
    assign bus.wr_addr2  = wr_addr2_q;
    assign bus.data1     = data1_q;
    assign bus.data2     = data2_q;
    assign bus.re_1      = re_1_q;
    assign bus.re_2      = re_2_q;
    assign bus.re_addr1  = re_addr1_q;
    assign bus.re_addr2  = re_addr2_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

`ifdef DUAL_MEM_SCHED_STATS_EN
    logic [31:0] stat_grants_q, stat_grants_d;
    logic [15:0] stat_stalls_q, stat_stalls_d;
    logic [2:0]  gcnt_c;
    logic [32:0] gsum_c;

    // Saturating grant and hazard-stall counters.
    always_comb begin
        gcnt_c        = 3'(w1_c) + 3'(w2_c) + 3'(r1_c) + 3'(r2_c);
        gsum_c        = 33'(stat_grants_q) + 33'(gcnt_c);
        stat_grants_d = gsum_c[32] ? '1 : gsum_c[31:0];
        stat_stalls_d = stat_stalls_q;
        if ((ww_haz_c || rw_haz_c) && (stat_stalls_q != '1)) begin
            stat_stalls_d = stat_stalls_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_grants_q <= stat_grants_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign bus.stat_grants = stat_grants_q;
    assign bus.stat_stalls = stat_stalls_q;
`endif
endmodule

// File: tb/tb_dual_mem_sched.sv
// Directed bench for dual_mem_sched with a behavioural dual_mem model.
`timescale 1ns/1ps
module tb_dual_mem_sched;
    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    dual_mem_sched_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bif ();

    dual_mem_sched #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    // dual_mem model: writes and reads at the rising edge, read data one cycle after re_x.
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            bif.read_out1 <= '0;
            bif.read_out2 <= '0;
        end else begin
            if (bif.we_1) mem[bif.wr_addr1] <= bif.data1;
            if (bif.we_2) mem[bif.wr_addr2] <= bif.data2;
            if (bif.re_1) bif.read_out1 <= mem[bif.re_addr1];
            if (bif.re_2) bif.read_out2 <= mem[bif.re_addr2];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bif.req_valid = '0;
        bif.req_we    = '0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
    endtask

    task automatic set_req(input int unsigned i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bif.req_valid[i]          = 1'b1;
        bif.req_we[i]             = we;
        bif.req_addr[i*AW +: AW]  = a;
        bif.req_wdata[i*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] rdata(input int unsigned i);
        return bif.rsp_data[i*DW +: DW];
    endfunction

    initial begin
        // Reset state, with a pending request that must not be accepted.
        rst = 1'b1;
        clr();
        set_req(0, 1'b1, 5'd11, 32'd10);
        tick();
        tick();
        chk("rst_ready",  64'(bif.req_ready), 64'h0);
        chk("rst_en",     64'({bif.we_1, bif.we_2, bif.re_1, bif.re_2}), 64'h0);
        chk("rst_rspv",   64'(bif.rsp_valid), 64'h0);
        chk("rst_rspd0",  64'(bif.rsp_data == '0), 64'h1);
        chk("rst_waddr",  64'({bif.wr_addr1, bif.data1}), 64'h0);

        // Write accepted in the first cycle with rst low.
        rst = 1'b0;
        #1;
        chk("w0_ready", 64'(bif.req_ready), 64'h1);
        tick();
        clr();
        chk("w0_we1",   64'(bif.we_1), 64'h1);
        chk("w0_addr1", 64'(bif.wr_addr1), 64'd11);
        chk("w0_data1", 64'(bif.data1), 64'd10);
        chk("w0_we2",   64'(bif.we_2), 64'h0);

        // Read back two cycles later; response three cycles after accept.
        tick();
        set_req(0, 1'b0, 5'd11, 32'd0);
        #1;
        chk("r0_ready", 64'(bif.req_ready), 64'h1);
        tick();
        clr();
        chk("r0_re1",   64'(bif.re_1), 64'h1);
        chk("r0_raddr", 64'(bif.re_addr1), 64'd11);
        chk("r0_re2",   64'(bif.re_2), 64'h0);
        tick();
        chk("r0_early", 64'(bif.rsp_valid), 64'h0);
        tick();
        chk("r0_rspv",  64'(bif.rsp_valid), 64'h1);
        chk("r0_rspd",  64'(rdata(0)), 64'd10);
        tick();
        chk("r0_pulse", 64'(bif.rsp_valid), 64'h0);

        // Four writes to distinct addresses: two per cycle in RR order.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + i);
        #1;
        chk("w4_ready_a", 64'(bif.req_ready), 64'h3);
        tick();
        bif.req_valid[0] = 1'b0;
        bif.req_valid[1] = 1'b0;
        chk("w4_slot_a", 64'({bif.we_1, bif.wr_addr1, bif.we_2, bif.wr_addr2}),
            64'({1'b1, 5'd1, 1'b1, 5'd2}));
        chk("w4_data_a", 64'({bif.data1, bif.data2}), {32'h100, 32'h101});
        #1;
        chk("w4_ready_b", 64'(bif.req_ready), 64'hC);
        tick();
        clr();
        chk("w4_slot_b", 64'({bif.we_1, bif.wr_addr1, bif.we_2, bif.wr_addr2}),
            64'({1'b1, 5'd3, 1'b1, 5'd4}));
        chk("w4_data_b", 64'({bif.data1, bif.data2}), {32'h102, 32'h103});
        for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'h0);
        #1;
        chk("w4_ptr0", 64'(bif.req_ready), 64'h3);
        clr();

        // Same-address writes: only one per cycle, later one wins in memory.
        tick();
        chk("idle_hold", 64'({bif.we_1, bif.wr_addr1}), 64'({1'b0, 5'd3}));
        set_req(1, 1'b1, 5'd7, 32'd5);
        set_req(2, 1'b1, 5'd7, 32'd6);
        #1;
        chk("ww_ready_a", 64'(bif.req_ready), 64'h2);
        tick();
        bif.req_valid[1] = 1'b0;
        chk("ww_slot_a", 64'({bif.we_1, bif.wr_addr1, bif.data1, bif.we_2}),
            64'({1'b1, 5'd7, 32'd5, 1'b0}));
        #1;
        chk("ww_ready_b", 64'(bif.req_ready), 64'h4);
        tick();
        clr();
        chk("ww_slot_b", 64'({bif.we_1, bif.wr_addr1, bif.data1}), 64'({1'b1, 5'd7, 32'd6}));
        set_req(0, 1'b0, 5'd7, 32'd0);
        #1;
        chk("ww_rd_ready", 64'(bif.req_ready), 64'h1);
        tick();
        clr();
        tick();
        tick();
        chk("ww_rd_rsp", 64'({bif.rsp_valid, rdata(0)}), 64'({4'h1, 32'd6}));

        // Read-write hazard: read stalls one cycle and sees the new data.
        tick();
        set_req(0, 1'b1, 5'd3, 32'd99);
        set_req(1, 1'b0, 5'd3, 32'd0);
        #1;
        chk("rw_ready_a", 64'(bif.req_ready), 64'h1);
        tick();
        bif.req_valid[0] = 1'b0;
        #1;
        chk("rw_ready_b", 64'(bif.req_ready), 64'h2);
        tick();
        clr();
        chk("rw_issue", 64'({bif.re_1, bif.re_addr1, bif.we_1}), 64'({1'b1, 5'd3, 1'b0}));
        tick();
        tick();
        chk("rw_rsp", 64'({bif.rsp_valid, rdata(1)}), 64'({4'h2, 32'd99}));

        // Two same-address reads in flight, then reset drops them.
        tick();
        set_req(1, 1'b0, 5'd11, 32'd0);
        set_req(2, 1'b0, 5'd11, 32'd0);
        #1;
        chk("rr_ready", 64'(bif.req_ready), 64'h6);
        tick();
        clr();
        chk("rr_issue", 64'({bif.re_1, bif.re_2, bif.re_addr1, bif.re_addr2}),
            64'({1'b1, 1'b1, 5'd11, 5'd11}));
        rst = 1'b1;
        tick();
        chk("mid_rst_en",   64'({bif.we_1, bif.we_2, bif.re_1, bif.re_2}), 64'h0);
        chk("mid_rst_addr", 64'({bif.re_addr1, bif.re_addr2}), 64'h0);
        rst = 1'b0;
        tick();
        chk("drop_a", 64'(bif.rsp_valid), 64'h0);
        tick();
        chk("drop_b", 64'(bif.rsp_valid), 64'h0);
        for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'(i + 1), 32'h0);
        #1;
        chk("rd_ptr0", 64'(bif.req_ready), 64'h3);
        clr();
        for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'h0);
        #1;
        chk("wr_ptr0", 64'(bif.req_ready), 64'h3);
        clr();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dual_mem_sched.md
Name: dual_mem_sched

Overview:
- Request scheduler in front of dual_mem (2 write slots, 2 read slots per cycle, 32x32).
- Accepts single-beat read/write requests from NREQ requesters.
- Grants up to 2 writes and 2 reads per cycle with independent round-robin pointers.
- Resolves same-cycle address hazards, drives dual_mem's we_/re_/addr/data pins from registers, and routes read_out1/read_out2 back to the issuing requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 5, address width (dual_mem depth 32).
- DW, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request present per requester.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  address; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  write data; requester i at [i*DW +: DW].
- req_ready  out  NREQ  combinational accept; a transfer occurs when valid && ready.
- rsp_valid  out  NREQ  one-cycle read-data pulse per requester.
- rsp_data  out  NREQ*DW  read data per requester.
- we_1, we_2  out  1  dual_mem write enables.
- wr_addr1, wr_addr2  out  AW  dual_mem write addresses.
- data1, data2  out  DW  dual_mem write data.
- re_1, re_2  out  1  dual_mem read enables.
- re_addr1, re_addr2  out  AW  dual_mem read addresses.
- read_out1, read_out2  in  DW  dual_mem read data; valid 1 cycle after re_x.

Behaviour:
- Reset (rst high at posedge):
  - All enables, rsp_valid, addresses, data and rsp_data go to 0.
  - Both RR pointers go to 0; the response tag pipeline is flushed.
  - req_ready is 0 while rst is high.
  - In-flight reads are dropped with no rsp_valid.
- Write arbitration, per cycle:
  - Scan requesters with valid && we, starting at wr_ptr and wrapping modulo NREQ.
  - First hit goes to slot 1. Next hit with a different address goes to slot 2.
  - A same-address second write is not granted and stalls (ready = 0).
- Read arbitration: same scan from rd_ptr over valid && !we. Two reads to the same address are both allowed.
- Read-write hazard: a read whose address equals any write granted this cycle is not granted. It retries next cycle and observes the new data.
- Pointer update: each pointer moves to (last granted index + 1) mod NREQ. It holds if nothing of that type was granted.
- Issue stage:
  - Grants at cycle T register onto dual_mem pins at T+1: we_x/re_x = 1 for one cycle, else 0.
  - Addresses and data hold their last value when the enable is 0.
- Read tags: each read slot carries a requester-index tag through a 2-stage pipeline.
  - At T+2, read_out_x is registered into rsp_data of the tagged requester, and that rsp_valid pulses high at T+3.
  - Total read latency is accept (T) to rsp_valid (T+3).
  - Both slots may complete in the same cycle for different requesters.
- Ordering: a read accepted after a write to the same address always returns the written data, because the issue register preserves order.
- Throughput: up to 2 writes + 2 reads per cycle, sustained; no bubbles apart from hazards.
- A requester with no grant keeps req_valid and its payload stable until accepted.
- Reset mid-operation clears everything in the same cycle. The next accept is possible in the first cycle with rst low.

Optional Feature:
- Macro: DUAL_MEM_SCHED_STATS_EN.
- Defined: adds outputs stat_grants (32-bit) and stat_stalls (16-bit), both saturating and cleared by rst.
  - stat_grants increments by the number of grants this cycle (0..4).
  - stat_stalls increments by 1 in any cycle where a valid request is refused because of a hazard (write-write or read-write address match). Plain slot contention does not count.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then req0 write addr 11 data 10 at T. Expect we_1 = 1, wr_addr1 = 11, data1 = 10 at T+1; req_ready[0] = 1 at T.
- Req0 read addr 11 two cycles later. Expect re_1 = 1, re_addr1 = 11; rsp_valid[0] = 1 with rsp_data = 10 three cycles after accept.
- All 4 requesters write distinct addresses 1..4 in one cycle, wr_ptr = 0. Expect req0/req1 granted, then req2/req3 next cycle; wr_ptr ends at 0.
- Req1 and req2 both write addr 7 (data 5, 6). Expect only req1 granted in cycle 1; req2 granted in cycle 2; a later read of addr 7 returns 6.
- Req0 write addr 3 data 99 and req1 read addr 3 in the same cycle. Expect req1 stalled one cycle, then its response is 99.
- Assert rst while two reads are in flight. Expect no rsp_valid afterwards, all mem enables 0, and pointers at 0.
